// File: rtl/rgb_column_former.sv
// Turns a raster-order RGB pixel stream into 3-row vertical columns for the conv layer.
// Optional sticky input-overrun detection is built when RGB_COLFORM_OVERRUN_EN is defined.
module rgb_column_former #(
    parameter int DATA_WIDTH = 8,
    parameter int WIDTH      = 224,
    parameter int HEIGHT     = 224
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    pix_valid,
    output logic                    pix_ready,
    input  logic [DATA_WIDTH-1:0]   pix_r,
    input  logic [DATA_WIDTH-1:0]   pix_g,
    input  logic [DATA_WIDTH-1:0]   pix_b,
    output logic                    col_valid,
    output logic [3*DATA_WIDTH-1:0] col_r,
    output logic [3*DATA_WIDTH-1:0] col_g,
    output logic [3*DATA_WIDTH-1:0] col_b,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    overrun
);

    // state  | meaning
    // IDLE   | waiting for start, input not accepted
    // FILL   | rows 0-1, pixels only load the line memories
    // STREAM | rows 2..HEIGHT-1, each accepted pixel emits a column
    // DONE   | final pixel taken, frame_done follows
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM, S_DONE} state_t;

    localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   col_cnt;
    logic [RW-1:0]   row_cnt;
    logic            accept;
    logic            start_acc;
    logic            col_last;
    logic            row_last;

    logic [DATA_WIDTH-1:0] l1_r [WIDTH];
    logic [DATA_WIDTH-1:0] l1_g [WIDTH];
    logic [DATA_WIDTH-1:0] l1_b [WIDTH];
    logic [DATA_WIDTH-1:0] l2_r [WIDTH];
    logic [DATA_WIDTH-1:0] l2_g [WIDTH];
    logic [DATA_WIDTH-1:0] l2_b [WIDTH];

    assign pix_ready = (state == S_FILL) || (state == S_STREAM);
    assign busy      = pix_ready;
    assign accept    = pix_valid && pix_ready;
    // frame_done marks the last cycle before a new start may be taken
    assign start_acc = start && (state == S_IDLE) && !frame_done;
    assign col_last  = (col_cnt == CW'(WIDTH - 1));
    assign row_last  = (row_cnt == RW'(HEIGHT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start_acc) state_nxt = S_FILL;
            S_FILL:   if (accept && col_last && (row_cnt == RW'(1))) state_nxt = S_STREAM;
            S_STREAM: if (accept && col_last && row_last) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (start_acc) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (accept) begin
            if (col_last) begin
                col_cnt <= '0;
                row_cnt <= row_last ? '0 : row_cnt + RW'(1);
            end else begin
                col_cnt <= col_cnt + CW'(1);
            end
        end
    end

    // Read-before-write: the shift L1->L2 and the new pixel into L1 share one edge
    always_ff @(posedge clk) begin
        if (accept) begin
            l2_r[col_cnt] <= l1_r[col_cnt];
            l2_g[col_cnt] <= l1_g[col_cnt];
            l2_b[col_cnt] <= l1_b[col_cnt];
            l1_r[col_cnt] <= pix_r;
            l1_g[col_cnt] <= pix_g;
            l1_b[col_cnt] <= pix_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_valid  <= 1'b0;
            col_r      <= '0;
            col_g      <= '0;
            col_b      <= '0;
            frame_done <= 1'b0;
        end else begin
            col_valid  <= accept && (state == S_STREAM);
            frame_done <= (state == S_DONE);
            if (accept && (state == S_STREAM)) begin
                col_r <= {l2_r[col_cnt], l1_r[col_cnt], pix_r};
                col_g <= {l2_g[col_cnt], l1_g[col_cnt], pix_g};
                col_b <= {l2_b[col_cnt], l1_b[col_cnt], pix_b};
            end
        end
    end

`ifdef RGB_COLFORM_OVERRUN_EN
    logic overrun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= (start_acc ? 1'b0 : overrun_q) | (pix_valid && !pix_ready);
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

endmodule
